mx_mac_acc_ctrl: RTL and testbench
==================================

MX_MAC_ACC_CTRL -- requirements
Module: mx_mac_acc_ctrl

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4: number of independent MX MAC accumulator lanes.
REQ-002 SHALL have parameter M_OUT_WIDTH, default 16: accumulator mantissa width per lane.
REQ-003 SHALL have parameter K_CNT_WIDTH, default 8: width of the per-tile accumulation-length counter.
REQ-004 SHALL have port clk_i  input  1  the only clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port k_len_i  input  K_CNT_WIDTH  number of beats per tile; sampled on a tile's first beat.
REQ-007 SHALL have ports A_valid_i and B_valid_i  input  1 each  operand-valid strobes.
REQ-008 SHALL have port in_ready_o  output  1  block can accept a beat.
REQ-009 SHALL have ports nxt_mant_i, nxt_exp_i and nxt_sign_i  input  NUM_LANES*M_OUT_WIDTH, NUM_LANES*8 and NUM_LANES  per-lane multiply-accumulate result from the upstream datapath.
REQ-010 SHALL have ports acc_mant_o, acc_exp_o and acc_sign_o  output  NUM_LANES*M_OUT_WIDTH, NUM_LANES*8 and NUM_LANES  accumulator feedback to the datapath.
REQ-011 SHALL have ports out_valid_o  output  1, and out_ready_i  input  1: tile-result handshake.
REQ-012 SHALL have ports out_mant_o, out_exp_o and out_sign_o  output  same widths as REQ-010  completed tile results.
REQ-013 SHALL have port busy_o  output  1  high when a tile is in progress or a result is pending.

Function
REQ-014 A beat SHALL be a cycle with A_valid_i & B_valid_i & in_ready_o; A_valid_i or B_valid_i alone SHALL change no state.
REQ-015 The FSM SHALL have states IDLE (no tile open), ACCUM (tile open, cnt beats taken) and HOLD (tile finished, output blocked).
REQ-016 A beat in IDLE SHALL latch k_len_i as K, with K=0 treated as 1, load all lanes from nxt_*_i, and set cnt=1.
REQ-017 A beat in ACCUM SHALL load all lanes from nxt_*_i and increment cnt.
REQ-018 Acc feedback SHALL be all-zero while in IDLE; otherwise it SHALL equal the accumulator registers.
REQ-019 The beat that makes cnt equal K SHALL complete the tile: the loaded value SHALL be copied to the output registers, out_valid_o SHALL rise the next cycle (latency 1), and cnt SHALL return to 0.
REQ-020 out_*_o SHALL stay stable while out_valid_o=1 and out_ready_i=0; out_valid_o SHALL clear after a cycle with out_valid_o & out_ready_i unless a new tile completes in that same cycle.
REQ-021 With no beat, the accumulators and cnt SHALL hold their values.
REQ-022 Changes to k_len_i during ACCUM SHALL be ignored.
REQ-023 busy_o SHALL equal (state!=IDLE) | out_valid_o.
REQ-024 Lanes SHALL be independent, with no carry, normalisation or cross-lane arithmetic in this block.

Reset
REQ-025 When rst_i=1 at a clock edge, the block SHALL set state=IDLE, cnt=0 and K=1, set all accumulator and output registers to 0, and drive out_valid_o=0; reset SHALL override any beat in the same cycle.
REQ-026 During reset, in_ready_o SHALL be 0; after reset it SHALL be 1, and a reset mid-tile SHALL discard the partial tile.

Configuration
REQ-027 Macro MX_MAC_ACC_DBUF_EN SHALL select the output buffering mode as follows.
REQ-028 Without MX_MAC_ACC_DBUF_EN: a completing beat SHALL go to HOLD if out_ready_i=0 at completion, else IDLE; in HOLD in_ready_o=0; HOLD SHALL exit to IDLE on the out handshake, with in_ready_o=1 from the next cycle.
REQ-029 With MX_MAC_ACC_DBUF_EN: HOLD SHALL be unused; the next tile SHALL accumulate while a result is pending; in_ready_o SHALL be 0 only when out_valid_o=1, out_ready_i=0 and the next beat would complete a tile (cnt==K-1 in ACCUM, or K<=1 in IDLE using k_len_i).

Verification
REQ-030 k_len_i=4, 4 back-to-back beats, lane0 nxt_mant_i=1,2,3,4 -> acc_mant_o lane0 is 0 on beat 1; out_valid_o=1 one cycle after beat 4 with out_mant_o lane0=4.
REQ-031 k_len_i=0, continuous beats, out_ready_i=1 -> every beat yields a result the next cycle, and out_valid_o stays high.
REQ-032 No DBUF, k_len_i=2, out_ready_i=0 for 5 cycles after completion -> in_ready_o=0 and out_*_o stable; out_ready_i=1 -> out_valid_o=0 and in_ready_o=1 the next cycle.
REQ-033 DBUF, k_len_i=2, out_ready_i=0 -> the second tile takes 1 beat, then in_ready_o=0; on release the first result is consumed, the second beat is accepted, and the second result is valid one cycle later.
REQ-034 rst_i=1 at cnt=2 of K=4 -> all outputs 0 and busy_o=0; the next beat opens a new tile with zero feedback.

Source files
------------

// File: rtl/mx_mac_acc_ctrl_if.sv
// Bus bundle for mx_mac_acc_ctrl: operand handshake, per-lane MAC result,
// accumulator feedback and tile-result handshake.
interface mx_mac_acc_ctrl_if #(
  parameter int NUM_LANES   = 4,
  parameter int M_OUT_WIDTH = 16,
  parameter int K_CNT_WIDTH = 8
);
  logic [K_CNT_WIDTH-1:0]           k_len_i;
  logic                             A_valid_i;
  logic                             B_valid_i;
  logic                             in_ready_o;
  logic [NUM_LANES*M_OUT_WIDTH-1:0] nxt_mant_i;
  logic [NUM_LANES*8-1:0]           nxt_exp_i;
  logic [NUM_LANES-1:0]             nxt_sign_i;
  logic [NUM_LANES*M_OUT_WIDTH-1:0] acc_mant_o;
  logic [NUM_LANES*8-1:0]           acc_exp_o;
  logic [NUM_LANES-1:0]             acc_sign_o;
  logic                             out_valid_o;
  logic                             out_ready_i;
  logic [NUM_LANES*M_OUT_WIDTH-1:0] out_mant_o;
  logic [NUM_LANES*8-1:0]           out_exp_o;
  logic [NUM_LANES-1:0]             out_sign_o;
  logic                             busy_o;

  modport slave (
    input  k_len_i, A_valid_i, B_valid_i, nxt_mant_i, nxt_exp_i, nxt_sign_i, out_ready_i,
    output in_ready_o, acc_mant_o, acc_exp_o, acc_sign_o,
           out_valid_o, out_mant_o, out_exp_o, out_sign_o, busy_o
  );

  modport master (
    output k_len_i, A_valid_i, B_valid_i, nxt_mant_i, nxt_exp_i, nxt_sign_i, out_ready_i,
    input  in_ready_o, acc_mant_o, acc_exp_o, acc_sign_o,
           out_valid_o, out_mant_o, out_exp_o, out_sign_o, busy_o
  );
endinterface

// File: rtl/mx_mac_acc_ctrl.sv
// MX MAC accumulator controller: per-lane accumulator/output registers plus tile FSM.
// Define MX_MAC_ACC_DBUF_EN to let the next tile accumulate while a result is pending.
module mx_mac_acc_lane #(
  parameter int MW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          acc_ld_i,
  input  logic          out_ld_i,
  input  logic          fb_zero_i,
  input  logic [MW-1:0] nxt_mant_i,
  input  logic [7:0]    nxt_exp_i,
  input  logic          nxt_sign_i,
  output logic [MW-1:0] acc_mant_o,
  output logic [7:0]    acc_exp_o,
  output logic          acc_sign_o,
  output logic [MW-1:0] out_mant_o,
  output logic [7:0]    out_exp_o,
  output logic          out_sign_o
);
  logic [MW-1:0] acc_mant_q, out_mant_q;
  logic [7:0]    acc_exp_q,  out_exp_q;
  logic          acc_sign_q, out_sign_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_mant_q <= '0; acc_exp_q <= '0; acc_sign_q <= 1'b0;
      out_mant_q <= '0; out_exp_q <= '0; out_sign_q <= 1'b0;
    end else begin
      if (acc_ld_i) begin
        acc_mant_q <= nxt_mant_i; acc_exp_q <= nxt_exp_i; acc_sign_q <= nxt_sign_i;
      end
      if (out_ld_i) begin
        out_mant_q <= nxt_mant_i; out_exp_q <= nxt_exp_i; out_sign_q <= nxt_sign_i;
      end
    end
  end

  // No tile open: the datapath must start from zero, not the stale accumulator.
  assign acc_mant_o = fb_zero_i ? '0   : acc_mant_q;
  assign acc_exp_o  = fb_zero_i ? '0   : acc_exp_q;
  assign acc_sign_o = fb_zero_i ? 1'b0 : acc_sign_q;
  assign out_mant_o = out_mant_q;
  assign out_exp_o  = out_exp_q;
  assign out_sign_o = out_sign_q;
endmodule

module mx_mac_acc_ctrl #(
  parameter int NUM_LANES   = 4,
  parameter int M_OUT_WIDTH = 16,
  parameter int K_CNT_WIDTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mx_mac_acc_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

  localparam logic [K_CNT_WIDTH-1:0] K_ONE = K_CNT_WIDTH'(1);

  state_e                 state_q;
  logic [K_CNT_WIDTH-1:0] cnt_q, k_q;
  logic                   out_valid_q;
  logic                   beat, last, stall, done, out_hs, in_ready;
  state_e                 done_state;

  assign out_hs = out_valid_q & bus.out_ready_i;
  assign last   = (state_q == IDLE)  ? (bus.k_len_i <= K_ONE) :
                  (state_q == ACCUM) ? (cnt_q == k_q - K_ONE) : 1'b0;
  // A completion while the previous result is still blocked would overwrite it.
  assign stall  = out_valid_q & ~bus.out_ready_i & last;

`ifdef MX_MAC_ACC_DBUF_EN
  assign in_ready   = ~rst_i & ~stall;
  assign done_state = IDLE;
`else
  assign in_ready   = ~rst_i & (state_q != HOLD) & ~stall;
  assign done_state = bus.out_ready_i ? IDLE : HOLD;
`endif

  assign beat = bus.A_valid_i & bus.B_valid_i & in_ready;
  assign done = beat & last;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      k_q         <= K_ONE;
      out_valid_q <= 1'b0;
    end else begin
      if (done)        out_valid_q <= 1'b1;
      else if (out_hs) out_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (beat) begin
          k_q <= (bus.k_len_i == '0) ? K_ONE : bus.k_len_i;
          if (last) begin
            cnt_q   <= '0;
            state_q <= done_state;
          end else begin
            cnt_q   <= K_ONE;
            state_q <= ACCUM;
          end
        end
        ACCUM: if (beat) begin
          if (last) begin
            cnt_q   <= '0;
            state_q <= done_state;
          end else begin
            cnt_q   <= cnt_q + K_ONE;
          end
        end
        HOLD: if (out_hs) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid_q;
  assign bus.busy_o      = (state_q != IDLE) | out_valid_q;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    mx_mac_acc_lane #(.MW(M_OUT_WIDTH)) u_lane (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .acc_ld_i   (beat),
      .out_ld_i   (done),
      .fb_zero_i  (state_q == IDLE),
      .nxt_mant_i (bus.nxt_mant_i[l*M_OUT_WIDTH +: M_OUT_WIDTH]),
      .nxt_exp_i  (bus.nxt_exp_i[l*8 +: 8]),
      .nxt_sign_i (bus.nxt_sign_i[l]),
      .acc_mant_o (bus.acc_mant_o[l*M_OUT_WIDTH +: M_OUT_WIDTH]),
      .acc_exp_o  (bus.acc_exp_o[l*8 +: 8]),
      .acc_sign_o (bus.acc_sign_o[l]),
      .out_mant_o (bus.out_mant_o[l*M_OUT_WIDTH +: M_OUT_WIDTH]),
      .out_exp_o  (bus.out_exp_o[l*8 +: 8]),
      .out_sign_o (bus.out_sign_o[l])
    );
  end
endmodule

// File: tb/tb_mx_mac_acc_ctrl.sv
// Directed bench for mx_mac_acc_ctrl; tile results are checked by a queue-based monitor.
module tb_mx_mac_acc_ctrl;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  mx_mac_acc_ctrl_if #(.NUM_LANES(4), .M_OUT_WIDTH(16), .K_CNT_WIDTH(8)) bus ();
  mx_mac_acc_ctrl #(.NUM_LANES(4), .M_OUT_WIDTH(16), .K_CNT_WIDTH(8)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  typedef struct packed {
    logic [63:0] m;
    logic [31:0] e;
    logic [3:0]  s;
  } res_t;

  res_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [63:0] mk_m(input int b);
    return {16'(b + 48), 16'(b + 32), 16'(b + 16), 16'(b)};
  endfunction
  function automatic logic [31:0] mk_e(input int b);
    return {8'(b + 103), 8'(b + 102), 8'(b + 101), 8'(b + 100)};
  endfunction
  function automatic logic [3:0] mk_s(input int b);
    return 4'(b);
  endfunction
  function automatic res_t mk_r(input int b);
    res_t r;
    r.m = mk_m(b); r.e = mk_e(b); r.s = mk_s(b);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%h req=%h @%0t", nm, act, req, $time);
    end
  endtask

  task automatic set_in(input logic a, input logic b, input logic [7:0] k, input int v);
    bus.A_valid_i  = a;
    bus.B_valid_i  = b;
    bus.k_len_i    = k;
    bus.nxt_mant_i = mk_m(v);
    bus.nxt_exp_i  = mk_e(v);
    bus.nxt_sign_i = mk_s(v);
  endtask

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  // One beat: inputs valid from just after a rising edge through the next one.
  task automatic beat(input int v, input logic [7:0] k, input bit do_acc,
                      input logic [63:0] acc_req, input bit do_ov);
    set_in(1'b1, 1'b1, k, v);
    @(negedge clk_i);
    chk("in_ready_beat", 64'(bus.in_ready_o), 64'd1);
    if (do_acc) chk("acc_mant", 64'(bus.acc_mant_o), acc_req);
    if (do_ov)  chk("out_valid_cont", 64'(bus.out_valid_o), 64'd1);
    step();
    bus.A_valid_i = 1'b0;
    bus.B_valid_i = 1'b0;
  endtask

  // Monitor: pops on every handshake and checks stability across stalls.
  bit   prev_stall = 1'b0;
  res_t prev_r;
  initial begin
    res_t cur, req;
    forever begin
      @(negedge clk_i);
      cur.m = bus.out_mant_o; cur.e = bus.out_exp_o; cur.s = bus.out_sign_o;
      if (prev_stall) begin
        chk("stall_valid", 64'(bus.out_valid_o), 64'd1);
        chk("stall_mant", cur.m, prev_r.m);
        chk("stall_exp_sign", {28'd0, cur.e, cur.s}, {28'd0, prev_r.e, prev_r.s});
      end
      if (bus.out_valid_o === 1'b1 && bus.out_ready_i === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", cur.m, 64'd0);
          if (cur.m == 64'd0) begin
            bad++;
            $display("FAIL unexpected_result act=valid req=none @%0t", $time);
          end
        end else begin
          req = exp_q.pop_front();
          chk("res_mant", cur.m, req.m);
          chk("res_exp", 64'(cur.e), 64'(req.e));
          chk("res_sign", 64'(cur.s), 64'(req.s));
        end
      end
      prev_stall = (bus.out_valid_o === 1'b1) && (bus.out_ready_i === 1'b0);
      prev_r     = cur;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_in(1'b0, 1'b0, 8'd0, 0);
    bus.out_ready_i = 1'b1;

    // Reset state
    step();
    @(negedge clk_i);
    chk("rst_in_ready", 64'(bus.in_ready_o), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_acc", 64'(bus.acc_mant_o), 64'd0);
    chk("rst_out", 64'(bus.out_mant_o), 64'd0);
    step();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_in_ready", 64'(bus.in_ready_o), 64'd1);
    step();

    // K=4 tile; lone A/B strobes and k_len changes mid-tile must be ignored
    beat(1, 8'd4, 1'b1, 64'd0, 1'b0);
    beat(2, 8'd1, 1'b1, mk_m(1), 1'b0);
    set_in(1'b1, 1'b0, 8'd1, 77); step();
    set_in(1'b0, 1'b1, 8'd1, 78); step();
    set_in(1'b0, 1'b0, 8'd1, 79);
    beat(3, 8'd1, 1'b1, mk_m(2), 1'b0);
    exp_q.push_back(mk_r(4));
    beat(4, 8'd1, 1'b1, mk_m(3), 1'b0);
    @(negedge clk_i);
    chk("t1_out_valid", 64'(bus.out_valid_o), 64'd1);
    step();
    @(negedge clk_i);
    chk("t1_out_clear", 64'(bus.out_valid_o), 64'd0);
    chk("t1_busy", 64'(bus.busy_o), 64'd0);
    step();

    // K=0 treated as 1: one result per beat, out_valid stays high
    for (int v = 5; v <= 8; v++) begin
      exp_q.push_back(mk_r(v));
      beat(v, 8'd0, 1'b1, 64'd0, v > 5);
    end
    step();

`ifdef MX_MAC_ACC_DBUF_EN
    // Second tile accumulates while the first result is blocked
    bus.out_ready_i = 1'b0;
    beat(9, 8'd2, 1'b1, 64'd0, 1'b0);
    exp_q.push_back(mk_r(10));
    beat(10, 8'd2, 1'b1, mk_m(9), 1'b0);
    beat(14, 8'd2, 1'b1, 64'd0, 1'b0);
    set_in(1'b1, 1'b1, 8'd2, 15);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("dbuf_in_ready_stall", 64'(bus.in_ready_o), 64'd0);
      chk("dbuf_acc", 64'(bus.acc_mant_o), mk_m(14));
      step();
    end
    exp_q.push_back(mk_r(15));
    bus.out_ready_i = 1'b1;
    @(negedge clk_i);
    chk("dbuf_in_ready_release", 64'(bus.in_ready_o), 64'd1);
    step();
    set_in(1'b0, 1'b0, 8'd2, 15);
    @(negedge clk_i);
    chk("dbuf_second_valid", 64'(bus.out_valid_o), 64'd1);
    step();
    @(negedge clk_i);
    chk("dbuf_clear", 64'(bus.out_valid_o), 64'd0);
`else
    // Blocked output: HOLD keeps inputs off and the result stable
    bus.out_ready_i = 1'b0;
    beat(9, 8'd2, 1'b1, 64'd0, 1'b0);
    exp_q.push_back(mk_r(10));
    beat(10, 8'd2, 1'b1, mk_m(9), 1'b0);
    set_in(1'b1, 1'b1, 8'd1, 99);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("hold_in_ready", 64'(bus.in_ready_o), 64'd0);
      chk("hold_busy", 64'(bus.busy_o), 64'd1);
      step();
    end
    set_in(1'b0, 1'b0, 8'd1, 99);
    bus.out_ready_i = 1'b1;
    step();
    @(negedge clk_i);
    chk("hold_out_clear", 64'(bus.out_valid_o), 64'd0);
    chk("hold_in_ready_back", 64'(bus.in_ready_o), 64'd1);
    chk("hold_busy_clear", 64'(bus.busy_o), 64'd0);
`endif
    step();

    // Reset mid-tile (cnt=2 of K=4) overrides a simultaneous beat
    beat(11, 8'd4, 1'b1, 64'd0, 1'b0);
    beat(12, 8'd4, 1'b1, mk_m(11), 1'b0);
    rst_i = 1'b1;
    set_in(1'b1, 1'b1, 8'd1, 50);
    @(negedge clk_i);
    chk("midrst_in_ready", 64'(bus.in_ready_o), 64'd0);
    step();
    rst_i = 1'b0;
    set_in(1'b0, 1'b0, 8'd1, 50);
    @(negedge clk_i);
    chk("midrst_out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("midrst_busy", 64'(bus.busy_o), 64'd0);
    chk("midrst_acc", 64'(bus.acc_mant_o), 64'd0);
    chk("midrst_out", 64'(bus.out_mant_o), 64'd0);
    step();
    exp_q.push_back(mk_r(13));
    beat(13, 8'd1, 1'b1, 64'd0, 1'b0);
    @(negedge clk_i);
    chk("post_rst_valid", 64'(bus.out_valid_o), 64'd1);
    step(); step(); step();

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
